// File: rtl/pdn_rail_sequencer.sv
// pdn_rail_sequencer: supply-side power-up sequencer for one shared VDD rail.
// Loads are switched on one at a time. Each power-up waits for power-good and
// is then followed by a stagger gap. The number of loads on at once is capped,
// and loads that never reach power-good are flagged.
//
// Optional feature macro: PDN_SEQ_TIMEOUT_EN
//   defined   : the RAMP timeout is active and sets sticky per-load fault bits.
//   undefined : RAMP waits indefinitely, fault is tied to 0 and fault_clr is ignored.
//
// Ports:
//   clk        rail controller clock
//   rst_n      asynchronous active-low reset
//   req        per-load power request (level)
//   pgood      per-load power-good, already synchronised
//   fault_clr  single-cycle pulse that clears all fault bits
//   sw_en      per-load power-switch enable (registered)
//   fault      sticky per-load timeout fault (registered)
//   on_count   population count of sw_en (registered)
//   busy       high whenever the sequencer is not in IDLE (registered)
module pdn_rail_sequencer #(
  parameter int unsigned NUM_LOADS      = 6,
  parameter int unsigned MAX_ON         = 3,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LOADS-1:0] req,
  input  logic [NUM_LOADS-1:0] pgood,
  input  logic                 fault_clr,
  output logic [NUM_LOADS-1:0] sw_en,
  output logic [NUM_LOADS-1:0] fault,
  output logic [4:0]           on_count,
  output logic                 busy
);

  localparam int unsigned IW = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;
`ifdef PDN_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > STAGGER_CYCLES) ? TIMEOUT_CYCLES
                                                                      : STAGGER_CYCLES;
`else
  localparam int unsigned CNT_MAX = STAGGER_CYCLES;
`endif
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [4:0]    MAX_ON_W = 5'(MAX_ON);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYCLES - 1);
`ifdef PDN_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1,
    STAGGER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_LOADS-1:0] sw_d;
  logic [NUM_LOADS-1:0] flt_q;
  logic [4:0]           on_d;
  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;

  function automatic logic [4:0] popcnt(input logic [NUM_LOADS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

`ifdef PDN_SEQ_TIMEOUT_EN
  logic [NUM_LOADS-1:0] flt_d;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign flt_q            = '0;
`endif

  assign fault = flt_q;
  assign on_d  = popcnt(sw_d);

  // Lowest-index load that is requesting, currently off and not faulted.
  // The loop runs downward so that the lowest matching index is written last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_LOADS - 1; i >= 0; i--) begin
      if (req[i] && !sw_en[i] && !flt_q[i]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end

  // Next-state, switch and fault update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    // Power-down applies in every state and ahead of any power-up decision.
    sw_d    = sw_en & req;
`ifdef PDN_SEQ_TIMEOUT_EN
    // A timeout set later in this block overrides the clear for its own bit.
    flt_d   = fault_clr ? '0 : flt_q;
`endif
    case (state_q)
      IDLE: begin
        // The slot check uses the count after this cycle's drops.
        if (pick_vld && (popcnt(sw_d) < MAX_ON_W)) begin
          sw_d[pick_idx] = 1'b1;
          idx_d          = pick_idx;
          cnt_d          = '0;
          state_d        = RAMP;
        end
      end
      RAMP: begin
        // A withdrawn request abandons the ramp with no fault and no stagger.
        if (!req[idx_q]) begin
          state_d = IDLE;
        end else if (pgood[idx_q]) begin
          cnt_d   = '0;
          state_d = STAGGER;
        end
`ifdef PDN_SEQ_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          sw_d[idx_q]  = 1'b0;
          flt_d[idx_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      STAGGER: begin
        if (cnt_q == STG_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset opens every switch immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      sw_en    <= '0;
      on_count <= '0;
      busy     <= 1'b0;
`ifdef PDN_SEQ_TIMEOUT_EN
      flt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sw_en    <= sw_d;
      on_count <= on_d;
      busy     <= (state_d != IDLE);
`ifdef PDN_SEQ_TIMEOUT_EN
      flt_q    <= flt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Testbench for pdn_rail_sequencer.
// A behavioural model (one ramping load, a stagger countdown, on/fault sets)
// predicts every cycle's outputs into a scoreboard queue. A negedge monitor
// pops and compares, and it also records switch edge times for the directed
// latency and spacing checks.
module tb_pdn_rail_sequencer;

  localparam int N   = 6;
  localparam int MAX = 3;
  localparam int S   = 16;
  localparam int T   = 64;
`ifdef PDN_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] pgood;
  logic         fault_clr;
  logic [N-1:0] sw_en;
  logic [N-1:0] fault;
  logic [4:0]   on_count;
  logic         busy;

  pdn_rail_sequencer #(
    .NUM_LOADS     (N),
    .MAX_ON        (MAX),
    .STAGGER_CYCLES(S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .pgood    (pgood),
    .fault_clr(fault_clr),
    .sw_en    (sw_en),
    .fault    (fault),
    .on_count (on_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] sw;
    logic [N-1:0] flt;
    logic [4:0]   cnt;
    logic         busy;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  bit [N-1:0] m_on;
  bit [N-1:0] m_flt;
  int         m_ramp;   // load currently ramping, -1 if none
  int         m_age;    // RAMP cycles already spent by m_ramp
  int         m_gap;    // stagger cycles still to wait
  int         age_on[N];
  int         pg_dly[N];
  bit         pg_dead[N];

  int         rise_cyc[N];
  int         fall_cyc[N];
  int         busy_cycles = 0;
  logic [N-1:0] prev_sw = '0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  function automatic void model_reset();
    m_on   = '0;
    m_flt  = '0;
    m_ramp = -1;
    m_age  = 0;
    m_gap  = 0;
    for (int j = 0; j < N; j++) age_on[j] = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] pg,
                                     input logic fc);
    bit [N-1:0] nxt;
    bit [N-1:0] nf;
    bit         found;
    nxt   = m_on & r;
    nf    = fc ? '0 : m_flt;
    found = 1'b0;
    if (m_ramp >= 0) begin
      if (!r[m_ramp]) begin
        m_ramp = -1;
      end else if (pg[m_ramp]) begin
        m_ramp = -1;
        m_gap  = S;
      end else if (TMO_EN && (m_age == T - 1)) begin
        nxt[m_ramp] = 1'b0;
        nf[m_ramp]  = 1'b1;
        m_ramp      = -1;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if ($countones(nxt) < MAX) begin
      for (int i = 0; i < N; i++) begin
        if (!found && r[i] && !m_on[i] && !m_flt[i]) begin
          found  = 1'b1;
          nxt[i] = 1'b1;
          m_ramp = i;
          m_age  = 0;
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      if (nxt[j] && !m_on[j]) age_on[j] = 0;
      else if (nxt[j])        age_on[j]++;
    end
    m_on  = nxt;
    m_flt = nf;
  endfunction

  // Drive pgood for this cycle, advance the model, queue the post-edge expectation.
  task automatic tick();
    logic [N-1:0] pg;
    pg = '0;
    for (int j = 0; j < N; j++) begin
      if (m_on[j]) begin
        if (j == m_ramp) pg[j] = !pg_dead[j] && (age_on[j] + 1 >= pg_dly[j]);
        else             pg[j] = ($urandom_range(0, 3) != 0);
      end
    end
    pgood = pg;
    if (!rst_n) model_reset();
    else        model_step(req, pg, fault_clr);
    sb.push_back('{cyc + 1, m_on, m_flt, 5'($countones(m_on)), (m_ramp >= 0) || (m_gap > 0)});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_loads(input int dly, input bit dead);
    for (int j = 0; j < N; j++) begin
      pg_dly[j]  = dly;
      pg_dead[j] = dead;
    end
  endtask

  // Reset asserted between edges, after this cycle's monitor sample.
  task automatic async_reset();
    #6;
    rst_n = 1'b0;
    #1;
    check("async_rst_sw_en", 32'(sw_en), 0);
    check("async_rst_on_count", 32'(on_count), 0);
    check("async_rst_busy", 32'(busy), 0);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor and edge recorder
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("sb_sw_en", 32'(sw_en), 32'(e.sw));
      check("sb_fault", 32'(fault), 32'(e.flt));
      check("sb_on_count", 32'(on_count), 32'(e.cnt));
      check("sb_busy", 32'(busy), 32'(e.busy));
    end
    for (int j = 0; j < N; j++) begin
      if (sw_en[j] && !prev_sw[j]) rise_cyc[j] = cyc;
      if (!sw_en[j] && prev_sw[j]) fall_cyc[j] = cyc;
    end
    prev_sw = sw_en;
    if (busy) busy_cycles++;
  end

  initial begin
    int c0;
    int c1;
    logic [N-1:0] nreq;

    rst_n     = 1'b0;
    req       = '0;
    pgood     = '0;
    fault_clr = 1'b0;
    set_loads(3, 1'b0);
    for (int j = 0; j < N; j++) begin
      rise_cyc[j] = -1000;
      fall_cyc[j] = -1000;
    end
    model_reset();
    #1;
    check("reset_sw_en", 32'(sw_en), 0);
    check("reset_fault", 32'(fault), 0);
    check("reset_on_count", 32'(on_count), 0);
    check("reset_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    run(2);
    rst_n = 1'b1;
    run(3);

    // Single load: 1-cycle switch-on latency, busy for ramp + stagger
    pg_dly[0]   = 5;
    req         = 6'b000001;
    c0          = cyc;
    busy_cycles = 0;
    run(30);
    check("t1_latency", rise_cyc[0] - c0, 1);
    check("t1_busy_cycles", busy_cycles, 5 + S);
    check("t1_on_count", 32'(on_count), 1);
    req = '0;
    run(3);

    // All loads at once: staggered power-ups, capped at MAX
    set_loads(3, 1'b0);
    req = '1;
    c0  = cyc;
    run(70);
    check("t2_first", rise_cyc[0] - c0, 1);
    check("t2_space01", rise_cyc[1] - rise_cyc[0], 1 + 3 + S);
    check("t2_space12", rise_cyc[2] - rise_cyc[1], 1 + 3 + S);
    check("t2_capped_sw", 32'(sw_en), 32'(6'b000111));
    check("t2_capped_cnt", 32'(on_count), MAX);
    req = 6'b111101;
    c1  = cyc;
    run(2);
    check("t2_drop1", fall_cyc[1] - c1, 1);
    check("t2_up3", rise_cyc[3] - c1, 1);
    req = '0;
    run(25);

`ifdef PDN_SEQ_TIMEOUT_EN
    // Timeout: fault, skip while faulted, retry after clear
    pg_dead[2] = 1'b1;
    req        = 6'b000100;
    run(70);
    check("t3_on_time", fall_cyc[2] - rise_cyc[2], T);
    check("t3_fault", 32'(fault), 32'(6'b000100));
    run(5);
    check("t3_skipped", 32'(sw_en), 0);
    pg_dead[2] = 1'b0;
    fault_clr  = 1'b1;
    c1         = cyc;
    tick();
    fault_clr  = 1'b0;
    run(3);
    check("t3_retry", rise_cyc[2] - c1, 2);
    check("t3_cleared", 32'(fault), 0);
    req = '0;
    run(25);
`else
    // No timeout: RAMP waits on pgood indefinitely
    pg_dead[0] = 1'b1;
    req        = 6'b000001;
    run(200);
    check("t6_sw_held", 32'(sw_en[0]), 1);
    check("t6_no_fault", 32'(fault), 0);
    check("t6_busy", 32'(busy), 1);
    req        = '0;
    pg_dead[0] = 1'b0;
    run(3);
`endif

    // Request withdrawn mid-RAMP
    pg_dly[4] = 10;
    req       = 6'b010000;
    c0        = cyc;
    run(4);
    req = '0;
    c1  = cyc;
    run(2);
    check("t4_rise", rise_cyc[4] - c0, 1);
    check("t4_fall", fall_cyc[4] - c1, 1);
    check("t4_fault", 32'(fault), 0);
    check("t4_idle", 32'(busy), 0);

    // Reset mid-STAGGER with three loads on, then restart from load 0
    set_loads(3, 1'b0);
    req = '1;
    run(50);
    check("t5_three_on", 32'(on_count), 3);
    async_reset();
    run(2);
    rst_n = 1'b1;
    c1    = cyc;
    run(3);
    check("t5_restart", rise_cyc[0] - c1, 1);
    check("t5_load0", 32'(sw_en), 32'(6'b000001));
    run(70);
    req = '0;
    run(25);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      nreq = req;
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 39) == 0) begin
          nreq[j] = ~nreq[j];
          if (nreq[j]) begin
            pg_dly[j]  = $urandom_range(1, 8);
            pg_dead[j] = ($urandom_range(0, 9) == 0);
          end
        end
      end
      req       = nreq;
      fault_clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 699) == 0) begin
        async_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    fault_clr = 1'b0;
    req       = '0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
